// File: rtl/riscv_multicycle_core.sv
// riscv_multicycle_core
// Multi-cycle RV32I core with one shared, handshaked memory port.
// Each instruction walks FETCH -> DECODE -> EXEC -> (MEM) -> (WB). Illegal
// encodings and misaligned targets/addresses park the core in HALT until reset.
//
// Optional feature macro: MC_MUL_EN
//   When defined, MUL (OP, funct7=0000001, funct3=000) is decoded and executed
//   as a 32-step shift-add in EXEC. When undefined, that encoding halts.
//
// Parameters:
//   RESET_PC  word-aligned PC loaded on reset
//   NUM_REGS  32 (RV32I) or 16 (RV32E); x0 always reads 0
//   ADDR_W    width of mem_addr (low bits of the byte address)
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   mem_req/mem_we       request valid / 1 = word store, 0 = word read
//   mem_addr/mem_wdata   word-aligned byte address / store data
//   mem_rdata/mem_ready  read data / request completes this cycle
//   PC_out_top           PC of the instruction in progress
//   Instruction_out_top  latched instruction register
//   retire               pulse in the final cycle of each completed instruction
//   halted               sticky fault indicator
module riscv_multicycle_core #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          NUM_REGS = 32,
    parameter int          ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic [31:0]       PC_out_top,
    output logic [31:0]       Instruction_out_top,
    output logic              retire,
    output logic              halted
);

    localparam int          IDX_W   = $clog2(NUM_REGS);
    localparam logic [31:0] NREGS_U = 32'(NUM_REGS);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [31:0]       r_pc;
    logic [31:0]       r_ir;
    logic [31:0]       r_a;
    logic [31:0]       r_b;
    logic [31:0]       r_imm;
    logic [31:0]       r_aluout;
    logic [31:0]       r_mdr;
    logic [31:0]       r_regs [NUM_REGS];
    logic              r_mem_req;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [31:0]       r_mem_wdata;
    logic              r_halted;
`ifdef MC_MUL_EN
    logic [4:0]        r_mul_cnt;
    logic              w_is_mul;
`endif

    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic [6:0]  w_funct7;
    logic [4:0]  w_rd;
    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    logic        w_is_jal, w_is_jalr, w_is_branch, w_is_load, w_is_store, w_is_op;
    logic        w_uses_rd, w_uses_rs1, w_uses_rs2;
    logic        w_idx_bad, w_illegal;
    logic [31:0] w_imm_dec;
    logic [31:0] w_rs1_val, w_rs2_val;
    logic        w_alt;
    logic [31:0] w_alu;
    logic        w_br_taken;
    logic        w_exec_fault;
    logic        w_mem_done;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_pc_next;
    logic        w_retire;
    logic        w_rf_we;
    logic [31:0] w_rf_wdata;

    // OP / OP-IMM arithmetic; alt selects SUB and SRA
    function automatic logic [31:0] alu_op(input logic [2:0] f3, input logic alt,
                                           input logic [31:0] a, input logic [31:0] b);
        logic [31:0] res;
        res = 32'd0;
        case (f3)
            3'b000:  res = alt ? (a - b) : (a + b);
            3'b001:  res = a << b[4:0];
            3'b010:  res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'b011:  res = (a < b) ? 32'd1 : 32'd0;
            3'b100:  res = a ^ b;
            3'b101:  res = alt ? 32'($signed(a) >>> b[4:0]) : (a >> b[4:0]);
            3'b110:  res = a | b;
            3'b111:  res = a & b;
            default: res = 32'd0;
        endcase
        return res;
    endfunction

    assign w_opcode    = r_ir[6:0];
    assign w_funct3    = r_ir[14:12];
    assign w_funct7    = r_ir[31:25];
    assign w_rd        = r_ir[11:7];
    assign w_rs1       = r_ir[19:15];
    assign w_rs2       = r_ir[24:20];
    assign w_is_jal    = (w_opcode == OPC_JAL);
    assign w_is_jalr   = (w_opcode == OPC_JALR);
    assign w_is_branch = (w_opcode == OPC_BRANCH);
    assign w_is_load   = (w_opcode == OPC_LOAD);
    assign w_is_store  = (w_opcode == OPC_STORE);
    assign w_is_op     = (w_opcode == OPC_OP);
`ifdef MC_MUL_EN
    assign w_is_mul    = w_is_op && (w_funct7 == 7'b0000001);
`endif

    // Register indices only matter for fields the format actually uses (RV32E check)
    assign w_uses_rd  = !(w_is_branch || w_is_store);
    assign w_uses_rs1 = !((w_opcode == OPC_LUI) || (w_opcode == OPC_AUIPC) || w_is_jal);
    assign w_uses_rs2 = w_is_branch || w_is_store || w_is_op;
    assign w_idx_bad  = (w_uses_rd  && ({27'd0, w_rd}  >= NREGS_U)) ||
                        (w_uses_rs1 && ({27'd0, w_rs1} >= NREGS_U)) ||
                        (w_uses_rs2 && ({27'd0, w_rs2} >= NREGS_U));

    assign w_rs1_val = (w_rs1 == 5'd0) ? 32'd0 : r_regs[w_rs1[IDX_W-1:0]];
    assign w_rs2_val = (w_rs2 == 5'd0) ? 32'd0 : r_regs[w_rs2[IDX_W-1:0]];

    // SUB only exists in OP; in OP-IMM bit 30 is only meaningful for SRAI
    assign w_alt      = r_ir[30] && (w_is_op || (w_funct3 == 3'b101));
    assign w_mem_done = r_mem_req && mem_ready;
    assign w_pc_plus4 = r_pc + 32'd4;

    // Supported-encoding check
    always_comb begin
        w_illegal = 1'b1;
        case (w_opcode)
            OPC_LUI, OPC_AUIPC, OPC_JAL: w_illegal = 1'b0;
            OPC_JALR:                    w_illegal = (w_funct3 != 3'b000);
            OPC_BRANCH:                  w_illegal = (w_funct3 == 3'b010) || (w_funct3 == 3'b011);
            OPC_LOAD, OPC_STORE:         w_illegal = (w_funct3 != 3'b010);
            OPC_OPIMM: begin
                case (w_funct3)
                    3'b001:  w_illegal = (w_funct7 != 7'b0000000);
                    3'b101:  w_illegal = (w_funct7 != 7'b0000000) && (w_funct7 != 7'b0100000);
                    default: w_illegal = 1'b0;
                endcase
            end
            OPC_OP: begin
                if (w_funct7 == 7'b0000000) begin
                    w_illegal = 1'b0;
                end else if (w_funct7 == 7'b0100000) begin
                    w_illegal = !((w_funct3 == 3'b000) || (w_funct3 == 3'b101));
                end else if (w_funct7 == 7'b0000001) begin
`ifdef MC_MUL_EN
                    w_illegal = (w_funct3 != 3'b000);
`else
                    w_illegal = 1'b1;
`endif
                end else begin
                    w_illegal = 1'b1;
                end
            end
            default: w_illegal = 1'b1;
        endcase
        w_illegal = w_illegal || w_idx_bad;
    end

    // Immediate extraction by instruction format
    always_comb begin
        w_imm_dec = {{20{r_ir[31]}}, r_ir[31:20]};
        case (w_opcode)
            OPC_LUI, OPC_AUIPC: w_imm_dec = {r_ir[31:12], 12'd0};
            OPC_JAL:    w_imm_dec = {{11{r_ir[31]}}, r_ir[31], r_ir[19:12], r_ir[20], r_ir[30:21], 1'b0};
            OPC_BRANCH: w_imm_dec = {{19{r_ir[31]}}, r_ir[31], r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0};
            OPC_STORE:  w_imm_dec = {{20{r_ir[31]}}, r_ir[31:25], r_ir[11:7]};
            default:    w_imm_dec = {{20{r_ir[31]}}, r_ir[31:20]};
        endcase
    end

    // EXEC result: ALU value, branch/jump target, or memory address
    always_comb begin
        w_alu = 32'd0;
        case (w_opcode)
            OPC_LUI:                         w_alu = r_imm;
            OPC_AUIPC, OPC_JAL, OPC_BRANCH:  w_alu = r_pc + r_imm;
            OPC_JALR:                        w_alu = (r_a + r_imm) & 32'hFFFF_FFFE;
            OPC_LOAD, OPC_STORE:             w_alu = r_a + r_imm;
            OPC_OP:                          w_alu = alu_op(w_funct3, w_alt, r_a, r_b);
            OPC_OPIMM:                       w_alu = alu_op(w_funct3, w_alt, r_a, r_imm);
            default:                         w_alu = 32'd0;
        endcase
    end

    // Branch condition
    always_comb begin
        w_br_taken = 1'b0;
        case (w_funct3)
            3'b000:  w_br_taken = (r_a == r_b);
            3'b001:  w_br_taken = (r_a != r_b);
            3'b100:  w_br_taken = ($signed(r_a) <  $signed(r_b));
            3'b101:  w_br_taken = ($signed(r_a) >= $signed(r_b));
            3'b110:  w_br_taken = (r_a <  r_b);
            3'b111:  w_br_taken = (r_a >= r_b);
            default: w_br_taken = 1'b0;
        endcase
    end

    // A non-taken branch never redirects, so its target alignment is irrelevant
    assign w_exec_fault = (w_is_load || w_is_store || w_is_jal || w_is_jalr ||
                           (w_is_branch && w_br_taken)) && (w_alu[1:0] != 2'b00);

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next state, next PC, retire and register-file write controls
    always_comb begin
        w_next_state = r_state;
        w_pc_next    = r_pc;
        w_retire     = 1'b0;
        w_rf_we      = 1'b0;
        w_rf_wdata   = r_aluout;
        case (r_state)
            S_FETCH: begin
                if (w_mem_done) begin
                    w_next_state = S_DECODE;
                end else begin
                    w_next_state = S_FETCH;
                end
            end
            S_DECODE: begin
                if (w_illegal) begin
                    w_next_state = S_HALT;
                end else begin
                    w_next_state = S_EXEC;
                end
            end
            S_EXEC: begin
`ifdef MC_MUL_EN
                if (w_is_mul) begin
                    if (r_mul_cnt == 5'd31) begin
                        w_next_state = S_WB;
                    end else begin
                        w_next_state = S_EXEC;
                    end
                end else if (w_exec_fault) begin
`else
                if (w_exec_fault) begin
`endif
                    w_next_state = S_HALT;
                end else if (w_is_branch) begin
                    w_next_state = S_FETCH;
                    w_retire     = 1'b1;
                    w_pc_next    = w_br_taken ? w_alu : w_pc_plus4;
                end else if (w_is_load || w_is_store) begin
                    w_next_state = S_MEM;
                end else begin
                    w_next_state = S_WB;
                end
            end
            S_MEM: begin
                if (w_mem_done && w_is_store) begin
                    w_next_state = S_FETCH;
                    w_retire     = 1'b1;
                    w_pc_next    = w_pc_plus4;
                end else if (w_mem_done) begin
                    w_next_state = S_WB;
                end else begin
                    w_next_state = S_MEM;
                end
            end
            S_WB: begin
                w_next_state = S_FETCH;
                w_retire     = 1'b1;
                w_rf_we      = (w_rd != 5'd0);
                if (w_is_load) begin
                    w_rf_wdata = r_mdr;
                end else if (w_is_jal || w_is_jalr) begin
                    w_rf_wdata = w_pc_plus4;
                end else begin
                    w_rf_wdata = r_aluout;
                end
                w_pc_next = (w_is_jal || w_is_jalr) ? r_aluout : w_pc_plus4;
            end
            S_HALT:  w_next_state = S_HALT;
            default: w_next_state = S_HALT;
        endcase
    end

    // Datapath registers, register file and registered memory-port outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc        <= RESET_PC;
            r_ir        <= 32'd0;
            r_a         <= 32'd0;
            r_b         <= 32'd0;
            r_imm       <= 32'd0;
            r_aluout    <= 32'd0;
            r_mdr       <= 32'd0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= 32'd0;
            r_halted    <= 1'b0;
`ifdef MC_MUL_EN
            r_mul_cnt   <= 5'd0;
`endif
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= 32'd0;
            end
        end else begin
            r_pc     <= w_pc_next;
            r_halted <= (w_next_state == S_HALT);
            case (r_state)
                S_FETCH: if (w_mem_done) r_ir <= mem_rdata;
                S_DECODE: begin
                    r_a   <= w_rs1_val;
                    r_b   <= w_rs2_val;
                    r_imm <= w_imm_dec;
                end
                S_EXEC: begin
`ifdef MC_MUL_EN
                    if (w_is_mul) begin
                        // Partial product for bit r_mul_cnt; the counter wraps to 0 on exit
                        r_aluout  <= ((r_mul_cnt == 5'd0) ? 32'd0 : r_aluout) +
                                     (r_b[r_mul_cnt] ? (r_a << r_mul_cnt) : 32'd0);
                        r_mul_cnt <= r_mul_cnt + 5'd1;
                    end else
`endif
                    if (!w_exec_fault) r_aluout <= w_alu;
                end
                S_MEM:   if (w_mem_done && w_is_load) r_mdr <= mem_rdata;
                S_WB:    if (w_rf_we) r_regs[w_rd[IDX_W-1:0]] <= w_rf_wdata;
                default: r_mdr <= r_mdr;
            endcase

            // Port outputs are set up for the state being entered, so a request
            // is presented from its first cycle and held until completion
            r_mem_req <= (w_next_state == S_FETCH) || (w_next_state == S_MEM);
            if (w_next_state == S_FETCH) begin
                r_mem_addr <= w_pc_next[ADDR_W-1:0];
                r_mem_we   <= 1'b0;
            end else if ((w_next_state == S_MEM) && (r_state == S_EXEC)) begin
                r_mem_addr  <= w_alu[ADDR_W-1:0];
                r_mem_we    <= w_is_store;
                r_mem_wdata <= r_b;
            end else if (w_next_state != S_MEM) begin
                r_mem_we <= 1'b0;
            end
        end
    end

    assign mem_req             = r_mem_req;
    assign mem_we              = r_mem_we;
    assign mem_addr            = r_mem_addr;
    assign mem_wdata           = r_mem_wdata;
    assign PC_out_top          = r_pc;
    assign Instruction_out_top = r_ir;
    assign retire              = w_retire;
    assign halted              = r_halted;

endmodule

// File: tb/tb_riscv_multicycle_core.sv
module tb_riscv_multicycle_core;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_req, mem_we, mem_ready, retire, halted;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, PC_out_top, Instruction_out_top;

    int          n_cmp  = 0;
    int          n_fail = 0;
    int          waits  = 0;
    int          wcnt   = 0;
    int          cyc    = 0;
    logic [31:0] mem [0:255];
    logic [31:0] l_addr, l_wdata;
    logic        l_we;
    int          retq [$];
    logic [31:0] pcq [$];
    int          exp_diff [$];
    logic [31:0] exp_pc [$];

    riscv_multicycle_core #(.RESET_PC(32'h100), .NUM_REGS(32), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .PC_out_top(PC_out_top), .Instruction_out_top(Instruction_out_top),
        .retire(retire), .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Memory completion and retire logging on the active edge (pre-update values)
    always @(posedge clk) begin
        if (retire) begin
            retq.push_back(cyc);
            pcq.push_back(PC_out_top);
        end
        cyc++;
        if (!mem_req) begin
            wcnt = 0;
        end else if (mem_ready) begin
            if (mem_we) mem[mem_addr[9:2]] = mem_wdata;
            wcnt = 0;
        end else begin
            wcnt++;
        end
    end

    // Memory response and request-stability checks on the opposite edge
    always @(negedge clk) begin
        if (mem_req && (wcnt != 0)) begin
            check("stable_addr", mem_addr, l_addr);
            check("stable_we", {31'd0, mem_we}, {31'd0, l_we});
            check("stable_wdata", mem_wdata, l_wdata);
        end else begin
            l_addr  = mem_addr;
            l_we    = mem_we;
            l_wdata = mem_wdata;
        end
        mem_ready = mem_req && (wcnt >= waits);
        mem_rdata = mem_req ? mem[mem_addr[9:2]] : 32'h0;
    end

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    endtask

    task automatic put(input logic [31:0] addr, input logic [31:0] w);
        mem[addr[9:2]] = w;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        retq.delete();
        pcq.delete();
    endtask

    task automatic wait_halt(input int max_cyc, input string tag);
        int n;
        n = 0;
        while (!halted && (n < max_cyc)) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(tag, {31'd0, halted}, 32'd1);
    endtask

    task automatic check_retires(input string tag);
        check({tag, "_count"}, retq.size(), exp_diff.size() + 1);
        for (int i = 1; i < retq.size() && i <= exp_diff.size(); i++)
            check({tag, "_cpi"}, retq[i] - retq[i-1], exp_diff[i-1]);
        for (int i = 0; i < pcq.size() && i < exp_pc.size(); i++)
            check({tag, "_pc"}, pcq[i], exp_pc[i]);
    endtask

    task automatic check_parked(input string tag, input logic [31:0] pc);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check({tag, "_req"}, {31'd0, mem_req}, 32'd0);
            check({tag, "_halted"}, {31'd0, halted}, 32'd1);
        end
        check({tag, "_pc"}, PC_out_top, pc);
    endtask

    initial begin
        mem_ready = 1'b0;
        mem_rdata = 32'h0;

        // ---- Reset + ALU/x0 program ----
        clear_mem();
        put(32'h100, 32'h00500093);   // addi x1,x0,5
        put(32'h104, 32'hFF908113);   // addi x2,x1,-7
        put(32'h108, 32'h00108033);   // add  x0,x1,x1
        put(32'h10C, 32'h401101B3);   // sub  x3,x2,x1
        put(32'h110, 32'h40115213);   // srai x4,x2,1
        put(32'h114, 32'h0020B2B3);   // sltu x5,x1,x2
        put(32'h118, 32'h0020A333);   // slt  x6,x1,x2
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("rst_req", {31'd0, mem_req}, 32'd0);
            check("rst_retire", {31'd0, retire}, 32'd0);
        end
        rst = 1'b0;
        retq.delete();
        pcq.delete();
        check("post_rst_req", {31'd0, mem_req}, 32'd0);
        check("post_rst_halted", {31'd0, halted}, 32'd0);
        check("post_rst_pc", PC_out_top, 32'h100);
        check("post_rst_ir", Instruction_out_top, 32'h0);
        @(posedge clk);
        #1;
        check("first_req", {31'd0, mem_req}, 32'd1);
        check("first_addr", mem_addr, 32'h100);
        check("first_we", {31'd0, mem_we}, 32'd0);
        wait_halt(200, "alu_halt");
        check("alu_x1", dut.r_regs[1], 32'h5);
        check("alu_x2", dut.r_regs[2], 32'hFFFF_FFFE);
        check("alu_x0", dut.r_regs[0], 32'h0);
        check("alu_sub", dut.r_regs[3], 32'hFFFF_FFF9);
        check("alu_srai", dut.r_regs[4], 32'hFFFF_FFFF);
        check("alu_sltu", dut.r_regs[5], 32'h1);
        check("alu_slt", dut.r_regs[6], 32'h0);
        check("alu_halt_pc", PC_out_top, 32'h11C);
        exp_diff = '{4, 4, 4, 4, 4, 4};
        exp_pc   = '{32'h100, 32'h104, 32'h108, 32'h10C, 32'h110, 32'h114, 32'h118};
        check_retires("alu");

        // ---- Wait states: SW then LW with 3 wait cycles per access ----
        clear_mem();
        waits = 3;
        put(32'h100, 32'hFFE00113);   // addi x2,x0,-2
        put(32'h104, 32'h00202423);   // sw   x2,8(x0)
        put(32'h108, 32'h00802183);   // lw   x3,8(x0)
        do_reset();
        wait_halt(400, "ws_halt");
        check("ws_store", mem[2], 32'hFFFF_FFFE);
        check("ws_x3", dut.r_regs[3], 32'hFFFF_FFFE);
        exp_diff = '{10, 11};
        exp_pc   = '{32'h100, 32'h104, 32'h108};
        check_retires("ws");
        waits = 0;

        // ---- Branches and jumps ----
        clear_mem();
        put(32'h100, 32'h00100293);   // addi x5,x0,1
        put(32'h104, 32'h00029663);   // bne  x5,x0,+12
        put(32'h108, 32'h00008067);   // jalr x0,0(x1)
        put(32'h10C, 32'h00100313);   // addi x6,x0,1 (skipped)
        put(32'h110, 32'hFF9FF0EF);   // jal  x1,-8
        put(32'h114, 32'h00028463);   // beq  x5,x0,+8 (not taken)
        do_reset();
        wait_halt(200, "br_halt");
        check("br_x1", dut.r_regs[1], 32'h114);
        check("br_x6", dut.r_regs[6], 32'h0);
        check("br_halt_pc", PC_out_top, 32'h118);
        exp_diff = '{3, 4, 4, 3};
        exp_pc   = '{32'h100, 32'h104, 32'h110, 32'h108, 32'h114};
        check_retires("br");

        // ---- Fault: misaligned load ----
        clear_mem();
        put(32'h100, 32'h00900393);   // addi x7,x0,9
        put(32'h104, 32'h00602383);   // lw   x7,6(x0)
        do_reset();
        wait_halt(200, "mis_halt");
        check_parked("mis", 32'h104);
        check("mis_ir", Instruction_out_top, 32'h00602383);
        check("mis_x7", dut.r_regs[7], 32'h9);
        check("mis_retires", retq.size(), 1);
        do_reset();
        check("mis_rst_clear", {31'd0, halted}, 32'd0);

        // ---- Fault: FENCE opcode ----
        clear_mem();
        put(32'h100, 32'h0000000F);
        do_reset();
        wait_halt(200, "fence_halt");
        check_parked("fence", 32'h100);
        check("fence_retires", retq.size(), 0);
        do_reset();
        check("fence_rst_clear", {31'd0, halted}, 32'd0);

        // ---- MUL ----
        clear_mem();
        put(32'h100, 32'hFFF00193);   // addi x3,x0,-1
        put(32'h104, 32'h00300213);   // addi x4,x0,3
        put(32'h108, 32'h024182B3);   // mul  x5,x3,x4
        do_reset();
        wait_halt(400, "mul_halt");
`ifdef MC_MUL_EN
        check("mul_x5", dut.r_regs[5], 32'hFFFF_FFFD);
        check("mul_halt_pc", PC_out_top, 32'h10C);
        exp_diff = '{4, 35};
        exp_pc   = '{32'h100, 32'h104, 32'h108};
`else
        check("mul_x5", dut.r_regs[5], 32'h0);
        check("mul_halt_pc", PC_out_top, 32'h108);
        exp_diff = '{4};
        exp_pc   = '{32'h100, 32'h104};
`endif
        check_retires("mul");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
